// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: examines one operand bit per clock,
// MSB first, and stops at the first differing bit. Supports unsigned and
// two's-complement operands. A new start is accepted in IDLE or in DONE,
// so that back-to-back comparisons run with no idle cycle between them.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_valid;
  logic             r_gt;
  logic             r_lt;
  logic             r_eq;

  logic             w_bit_a;
  logic             w_bit_b;
  logic             w_bits_differ;
  logic             w_a_wins;
  logic             w_accept;

  // Decide which operand is larger from the first differing bit. At the
  // sign position of a signed compare the set bit marks the negative
  // (smaller) operand, so the sense is inverted there only.
  function automatic logic a_is_greater(input logic bit_a,
                                        input logic sgn,
                                        input logic at_msb);
    a_is_greater = (sgn && at_msb) ? ~bit_a : bit_a;
  endfunction

  // Current bit pair under examination and the resulting decision
  always_comb begin
    w_bit_a       = r_a[r_idx];
    w_bit_b       = r_b[r_idx];
    w_bits_differ = w_bit_a ^ w_bit_b;
    w_a_wins      = a_is_greater(w_bit_a, r_signed, (r_idx == IDX_MSB));
    w_accept      = start && ((r_state == IDLE) || (r_state == DONE));
  end

  // Control FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= IDX_MSB;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_gt     <= 1'b0;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless set again below
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= is_signed;
            r_idx    <= IDX_MSB;
            r_valid  <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else if (r_state == DONE) begin
            // Result stays held in IDLE until the next accepted start
            r_state <= IDLE;
          end
        end
        RUN: begin
          if (w_bits_differ) begin
            r_gt    <= w_a_wins;
            r_lt    <= ~w_a_wins;
            r_valid <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else if (r_idx == '0) begin
            // Last bit equal: operands identical, index never wraps
            r_eq    <= 1'b1;
            r_valid <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign valid = r_valid;
  assign gt    = r_gt;
  assign lt    = r_lt;
  assign eq    = r_eq;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator (WIDTH=8): a vector table of
// operand pairs with hand-computed results and RUN-edge counts, followed by
// hand-written sequences for start-while-busy, back-to-back and mid-run reset.
module tb_serial_mag_comparator;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic             valid;
  logic             gt;
  logic             lt;
  logic             eq;

  int n_checks = 0;
  int n_err    = 0;

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .valid     (valid),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vs;
    logic       egt;
    logic       elt;
    logic       eeq;
    int         eruns;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge. Launches a compare, returns at the negedge where
  // done is seen (or after a bounded wait). runs = RUN edges until done,
  // bcyc = sampled cycles with busy high, vcyc = busy cycles with valid high.
  task automatic do_compare(input logic [7:0] ta, input logic [7:0] tb,
                            input logic ts, output int runs,
                            output int bcyc, output int vcyc);
    a = ta; b = tb; is_signed = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    runs = 0; bcyc = 0; vcyc = 0;
    while (!done && runs < 20) begin
      if (busy) bcyc++;
      if (busy && valid) vcyc++;
      @(negedge clk);
      runs++;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, busy},  32'd0);
    chk({tag, "_done"},  {31'd0, done},  32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_gtlteq"}, {29'd0, gt, lt, eq}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int runs, bcyc, vcyc;
    int ndone;

    vecs[0]  = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[2]  = '{8'hFF, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0, 8};
    vecs[3]  = '{8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8};
    vecs[4]  = '{8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 7};
    vecs[5]  = '{8'h7F, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[6]  = '{8'h05, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 8};
    vecs[7]  = '{8'hC0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    vecs[8]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8};
    vecs[9]  = '{8'hFE, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8};
    vecs[10] = '{8'h40, 8'h3F, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    vecs[11] = '{8'h3F, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0, 2};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("idle");

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      do_compare(vecs[i].va, vecs[i].vb, vecs[i].vs, runs, bcyc, vcyc);
      chk($sformatf("v%0d_runs", i), runs, vecs[i].eruns);
      chk($sformatf("v%0d_busycyc", i), bcyc, vecs[i].eruns);
      chk($sformatf("v%0d_validinrun", i), vcyc, 0);
      chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_valid", i), {31'd0, valid}, 32'd1);
      chk($sformatf("v%0d_gtlteq", i), {29'd0, gt, lt, eq},
          {29'd0, vecs[i].egt, vecs[i].elt, vecs[i].eeq});
      // Result must be held in IDLE even as the operand inputs change
      a = ~vecs[i].va; b = vecs[i].va; is_signed = ~vecs[i].vs;
      @(negedge clk);
      chk($sformatf("v%0d_donepulse", i), {31'd0, done}, 32'd0);
      a = 8'h00; b = 8'hFF;
      @(negedge clk);
      chk($sformatf("v%0d_hold_valid", i), {31'd0, valid}, 32'd1);
      chk($sformatf("v%0d_hold_busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_hold_gtlteq", i), {29'd0, gt, lt, eq},
          {29'd0, vecs[i].egt, vecs[i].elt, vecs[i].eeq});
    end

    // Start while busy is ignored
    a = 8'h03; b = 8'h02; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    runs = 0;
    @(negedge clk); runs++;
    @(negedge clk); runs++;
    a = 8'h00; b = 8'hFF; start = 1'b1;
    @(negedge clk); runs++;
    start = 1'b0; a = 8'h55; b = 8'hAA;
    while (!done && runs < 20) begin
      @(negedge clk);
      runs++;
    end
    chk("ign_runs", runs, 8);
    chk("ign_gtlteq", {29'd0, gt, lt, eq}, {29'd0, 3'b100});
    @(negedge clk);
    chk("ign_nosecond_busy", {31'd0, busy}, 32'd0);
    chk("ign_nosecond_valid", {31'd0, valid}, 32'd1);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("ign_no_activity", ndone, 0);

    // Back-to-back: new start presented in the DONE cycle
    do_compare(8'h80, 8'h7F, 1'b0, runs, bcyc, vcyc);
    chk("b2b_first_runs", runs, 1);
    chk("b2b_first_gt", {31'd0, gt}, 32'd1);
    do_compare(8'h10, 8'h20, 1'b0, runs, bcyc, vcyc);
    chk("b2b_runs", runs, 3);
    chk("b2b_busycyc", bcyc, 3);
    chk("b2b_validinrun", vcyc, 0);
    chk("b2b_gtlteq", {29'd0, gt, lt, eq}, {29'd0, 3'b010});
    @(negedge clk);

    // Reset in the 4th RUN cycle, then start in the first cycle after reset
    a = 8'hAA; b = 8'hAA; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_midrun_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_outputs_zero("rst_mid");
    rst = 1'b0;
    do_compare(8'h01, 8'h01, 1'b0, runs, bcyc, vcyc);
    chk("rst_after_runs", runs, 8);
    chk("rst_after_busycyc", bcyc, 8);
    chk("rst_after_eq", {29'd0, gt, lt, eq}, {29'd0, 3'b001});
    chk("rst_after_valid", {31'd0, valid}, 32'd1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
